// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap controller.
// Optional exception path is enabled with TRAP_CTRL_EXP_EN.
package trap_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRAP_SAVE = 3'd1,
    ST_TRAP_JUMP = 3'd2,
    ST_MRET_RST  = 3'd3,
    ST_MRET_JUMP = 3'd4
  } state_e;

  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SFT    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TMR    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

  function automatic data_t fit_cause(logic [31:0] c);
    return data_t'(c);
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// EX-stage, CSR and pipeline-control bundle of the trap controller.
// slave is the controller side, master the surrounding core side.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  addr_t pc_ex_i;
  logic  ex_valid_i;
  logic  ecall_i;
  logic  ebreak_i;
  logic  mret_i;
  logic  i_ext_irq;
  logic  i_sft_irq;
  logic  i_tmr_irq;
  logic  meie_i;
  logic  msie_i;
  logic  mtie_i;
  logic  glb_irq_i;
  addr_t mtvec_i;
  addr_t mepc_i;

  logic  o_irq_src;
  logic  o_exp_src;
  logic  o_mret_ena;
  data_t o_mcause;
  addr_t o_trap_pc;
  logic  o_hold;
  logic  o_flush;
  logic  o_jump_ena;
  addr_t o_jump_addr;

  modport slave (
    input  pc_ex_i, ex_valid_i,
    input  ecall_i, ebreak_i, mret_i,
    input  i_ext_irq, i_sft_irq, i_tmr_irq,
    input  meie_i, msie_i, mtie_i, glb_irq_i,
    input  mtvec_i, mepc_i,
    output o_irq_src, o_exp_src, o_mret_ena,
    output o_mcause, o_trap_pc,
    output o_hold, o_flush,
    output o_jump_ena, o_jump_addr
  );

  modport master (
    output pc_ex_i, ex_valid_i,
    output ecall_i, ebreak_i, mret_i,
    output i_ext_irq, i_sft_irq, i_tmr_irq,
    output meie_i, msie_i, mtie_i, glb_irq_i,
    output mtvec_i, mepc_i,
    input  o_irq_src, o_exp_src, o_mret_ena,
    input  o_mcause, o_trap_pc,
    input  o_hold, o_flush,
    input  o_jump_ena, o_jump_addr
  );

endinterface

// File: rtl/trap_ctrl_arb.sv
// trap_arb: combinational trap priority and mcause encoding.
// ecall/ebreak only participate when TRAP_CTRL_EXP_EN is defined.
module trap_arb
  import trap_ctrl_pkg::*;
(
  input  logic  ex_valid_i,
  input  logic  ecall_i,
  input  logic  ebreak_i,
  input  logic  mret_i,
  input  logic  i_ext_irq,
  input  logic  i_sft_irq,
  input  logic  i_tmr_irq,
  input  logic  meie_i,
  input  logic  msie_i,
  input  logic  mtie_i,
  input  logic  glb_irq_i,
  output logic  take_o,
  output logic  irq_o,
  output logic  mret_o,
  output data_t mcause_o
);

  logic ext_ok;
  logic sft_ok;
  logic tmr_ok;
  logic ecall_ok;
  logic ebreak_ok;

  assign ext_ok = glb_irq_i & meie_i & i_ext_irq;
  assign sft_ok = glb_irq_i & msie_i & i_sft_irq;
  assign tmr_ok = glb_irq_i & mtie_i & i_tmr_irq;

`ifdef TRAP_CTRL_EXP_EN
  assign ecall_ok  = ecall_i;
  assign ebreak_ok = ebreak_i;
`else
  logic unused_exp;
  assign unused_exp = ecall_i | ebreak_i;
  assign ecall_ok   = 1'b0;
  assign ebreak_ok  = 1'b0;
`endif

  always_comb begin
    take_o   = 1'b0;
    irq_o    = 1'b0;
    mret_o   = 1'b0;
    mcause_o = '0;
    if (ex_valid_i) begin
      if (ecall_ok) begin
        take_o   = 1'b1;
        mcause_o = fit_cause(CAUSE_ECALL);
      end else if (ebreak_ok) begin
        take_o   = 1'b1;
        mcause_o = fit_cause(CAUSE_EBREAK);
      end else if (mret_i) begin
        take_o = 1'b1;
        mret_o = 1'b1;
      end else if (ext_ok) begin
        take_o   = 1'b1;
        irq_o    = 1'b1;
        mcause_o = fit_cause(CAUSE_EXT);
      end else if (sft_ok) begin
        take_o   = 1'b1;
        irq_o    = 1'b1;
        mcause_o = fit_cause(CAUSE_SFT);
      end else if (tmr_ok) begin
        take_o   = 1'b1;
        irq_o    = 1'b1;
        mcause_o = fit_cause(CAUSE_TMR);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: detect, save (CSR pulse), jump with flush.
// Exceptions (ecall/ebreak) are built in only with TRAP_CTRL_EXP_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus
);

  logic  take;
  logic  irq;
  logic  mret;
  data_t cause;

  trap_arb u_arb (
    .ex_valid_i (bus.ex_valid_i),
    .ecall_i    (bus.ecall_i),
    .ebreak_i   (bus.ebreak_i),
    .mret_i     (bus.mret_i),
    .i_ext_irq  (bus.i_ext_irq),
    .i_sft_irq  (bus.i_sft_irq),
    .i_tmr_irq  (bus.i_tmr_irq),
    .meie_i     (bus.meie_i),
    .msie_i     (bus.msie_i),
    .mtie_i     (bus.mtie_i),
    .glb_irq_i  (bus.glb_irq_i),
    .take_o     (take),
    .irq_o      (irq),
    .mret_o     (mret),
    .mcause_o   (cause)
  );

  state_e state_q;
  logic   irq_q;
  data_t  mcause_q;
  addr_t  trap_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      mcause_q  <= '0;
      trap_pc_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (take && mret) begin
            state_q <= ST_MRET_RST;
          end else if (take) begin
            state_q   <= ST_TRAP_SAVE;
            irq_q     <= irq;
            mcause_q  <= cause;
            trap_pc_q <= bus.pc_ex_i;
          end
        end
        ST_TRAP_SAVE: state_q <= ST_TRAP_JUMP;
        ST_TRAP_JUMP: state_q <= ST_IDLE;
        ST_MRET_RST:  state_q <= ST_MRET_JUMP;
        ST_MRET_JUMP: state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps every control output low while reset is held.
  always_comb begin
    bus.o_hold      = 1'b0;
    bus.o_flush     = 1'b0;
    bus.o_jump_ena  = 1'b0;
    bus.o_jump_addr = '0;
    bus.o_irq_src   = 1'b0;
    bus.o_exp_src   = 1'b0;
    bus.o_mret_ena  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: bus.o_hold = take;
        ST_TRAP_SAVE: begin
          bus.o_hold    = 1'b1;
          bus.o_irq_src = irq_q;
`ifdef TRAP_CTRL_EXP_EN
          bus.o_exp_src = ~irq_q;
`endif
        end
        ST_TRAP_JUMP: begin
          bus.o_flush     = 1'b1;
          bus.o_jump_ena  = 1'b1;
          bus.o_jump_addr = {bus.mtvec_i[ADDR_W-1:2], 2'b00};
        end
        ST_MRET_RST: begin
          bus.o_hold     = 1'b1;
          bus.o_mret_ena = 1'b1;
        end
        ST_MRET_JUMP: begin
          bus.o_flush     = 1'b1;
          bus.o_jump_ena  = 1'b1;
          bus.o_jump_addr = bus.mepc_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mcause  = mcause_q;
  assign bus.o_trap_pc = trap_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: cycle-level reference model plus directed cases.
// Expectations follow TRAP_CTRL_EXP_EN when it is defined.
module tb_trap_ctrl;

`ifdef TRAP_CTRL_EXP_EN
  localparam bit EXP = 1'b1;
`else
  localparam bit EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a trap takes 3 cycles (detect, save, jump).
  int          seq = 0;
  bit          m_irq = 1'b0;
  bit          m_mret = 1'b0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_pc = '0;

  task automatic decide(output bit tk, output bit iq,
                        output bit mr, output logic [31:0] c);
    bit ext, sft, tmr;
    tk = 1'b0; iq = 1'b0; mr = 1'b0; c = '0;
    ext = bus.glb_irq_i && bus.meie_i && bus.i_ext_irq;
    sft = bus.glb_irq_i && bus.msie_i && bus.i_sft_irq;
    tmr = bus.glb_irq_i && bus.mtie_i && bus.i_tmr_irq;
    if (!bus.ex_valid_i) return;
    if (EXP && bus.ecall_i) begin
      tk = 1; c = 32'h0000000B;
    end else if (EXP && bus.ebreak_i) begin
      tk = 1; c = 32'h00000003;
    end else if (bus.mret_i) begin
      tk = 1; mr = 1;
    end else if (ext) begin
      tk = 1; iq = 1; c = 32'h8000000B;
    end else if (sft) begin
      tk = 1; iq = 1; c = 32'h80000003;
    end else if (tmr) begin
      tk = 1; iq = 1; c = 32'h80000007;
    end
  endtask

  always @(posedge clk) begin
    bit tk, iq, mr;
    logic [31:0] c;
    decide(tk, iq, mr, c);
    if (!rst_n) begin
      seq = 0; m_cause = '0; m_pc = '0;
    end else if (seq == 0) begin
      if (tk) begin
        seq = 1; m_irq = iq; m_mret = mr;
        if (!mr) begin
          m_cause = c; m_pc = bus.pc_ex_i;
        end
      end
    end else if (seq == 1) begin
      seq = 2;
    end else begin
      seq = 0;
    end
  end

  always @(negedge clk) begin
    bit tk, iq, mr;
    logic [31:0] c;
    logic [31:0] e_addr;
    bit jmp;
    if (chk_en) begin
      decide(tk, iq, mr, c);
      jmp = rst_n && seq == 2;
      e_addr = !jmp ? 32'h0 :
               m_mret ? bus.mepc_i : bus.mtvec_i & ~32'h3;
      chk("m_hold", 32'(bus.o_hold),
          32'(rst_n && ((seq == 0 && tk) || seq == 1)));
      chk("m_irq_src", 32'(bus.o_irq_src),
          32'(rst_n && seq == 1 && !m_mret && m_irq));
      chk("m_exp_src", 32'(bus.o_exp_src),
          32'(rst_n && seq == 1 && !m_mret && !m_irq));
      chk("m_mret_ena", 32'(bus.o_mret_ena),
          32'(rst_n && seq == 1 && m_mret));
      chk("m_jump_ena", 32'(bus.o_jump_ena), 32'(jmp));
      chk("m_flush", 32'(bus.o_flush), 32'(jmp));
      chk("m_jump_addr", bus.o_jump_addr, e_addr);
      chk("m_mcause", bus.o_mcause, m_cause);
      chk("m_trap_pc", bus.o_trap_pc, m_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.ex_valid_i = 0; bus.ecall_i = 0;
    bus.ebreak_i = 0; bus.mret_i = 0;
    bus.i_ext_irq = 0; bus.i_sft_irq = 0;
    bus.i_tmr_irq = 0;
  endtask

  initial begin
    bus.pc_ex_i = '0; bus.mtvec_i = '0; bus.mepc_i = '0;
    bus.meie_i = 0; bus.msie_i = 0; bus.mtie_i = 0;
    bus.glb_irq_i = 0;
    quiet();
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_mcause", bus.o_mcause, 32'h0);
    chk("rst_trap_pc", bus.o_trap_pc, 32'h0);
    chk("rst_jump_addr", bus.o_jump_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // Timer interrupt
    bus.glb_irq_i = 1; bus.mtie_i = 1; bus.meie_i = 1;
    bus.msie_i = 1; bus.mtvec_i = 32'h80;
    bus.pc_ex_i = 32'h100; bus.ex_valid_i = 1;
    bus.i_tmr_irq = 1;
    #1 chk("tmr_hold_det", 32'(bus.o_hold), 32'h1);
    tick(); quiet();
    #1 chk("tmr_irq_src", 32'(bus.o_irq_src), 32'h1);
    chk("tmr_hold_save", 32'(bus.o_hold), 32'h1);
    chk("tmr_mcause", bus.o_mcause, 32'h80000007);
    chk("tmr_trap_pc", bus.o_trap_pc, 32'h100);
    tick();
    #1 chk("tmr_jump", 32'(bus.o_jump_ena), 32'h1);
    chk("tmr_flush", 32'(bus.o_flush), 32'h1);
    chk("tmr_addr", bus.o_jump_addr, 32'h80);
    chk("tmr_hold_jmp", 32'(bus.o_hold), 32'h0);
    chk("tmr_mcause_jmp", bus.o_mcause, 32'h80000007);
    tick();
    #1 chk("tmr_done", 32'(bus.o_jump_ena), 32'h0);

    // ecall with external irq pending
    bus.mtvec_i = 32'h203; bus.pc_ex_i = 32'h200;
    bus.ex_valid_i = 1; bus.ecall_i = 1; bus.i_ext_irq = 1;
    tick(); quiet();
`ifdef TRAP_CTRL_EXP_EN
    #1 chk("ecall_exp", 32'(bus.o_exp_src), 32'h1);
    chk("ecall_no_irq", 32'(bus.o_irq_src), 32'h0);
    chk("ecall_cause", bus.o_mcause, 32'h0000000B);
`else
    #1 chk("ecall_ign_irq", 32'(bus.o_irq_src), 32'h1);
    chk("ecall_ign_exp", 32'(bus.o_exp_src), 32'h0);
    chk("ecall_ign_cause", bus.o_mcause, 32'h8000000B);
`endif
    chk("ecall_pc", bus.o_trap_pc, 32'h200);
    tick();
    #1 chk("ecall_addr", bus.o_jump_addr, 32'h200);
    tick();

    // mret
    bus.mepc_i = 32'h104; bus.ex_valid_i = 1; bus.mret_i = 1;
    #1 chk("mret_hold", 32'(bus.o_hold), 32'h1);
    tick(); quiet();
    #1 chk("mret_ena", 32'(bus.o_mret_ena), 32'h1);
    tick();
    #1 chk("mret_jump", 32'(bus.o_jump_ena), 32'h1);
    chk("mret_addr", bus.o_jump_addr, 32'h104);
    chk("mret_cause_kept", bus.o_mcause,
        EXP ? 32'h0000000B : 32'h8000000B);
    tick();

    // Masked / bubble cases
    bus.glb_irq_i = 0; bus.ex_valid_i = 1; bus.i_ext_irq = 1;
    #1 chk("glb0_hold", 32'(bus.o_hold), 32'h0);
    tick(); tick();
    bus.glb_irq_i = 1; bus.ex_valid_i = 0;
    #1 chk("bubble_hold", 32'(bus.o_hold), 32'h0);
    tick(); tick(); quiet();
    bus.mtie_i = 0; bus.ex_valid_i = 1; bus.i_tmr_irq = 1;
    #1 chk("mtie0_hold", 32'(bus.o_hold), 32'h0);
    tick(); quiet();
    bus.mtie_i = 1;
    bus.ex_valid_i = 1; bus.ebreak_i = 1;
    #1 chk("ebreak_hold", 32'(bus.o_hold), 32'(EXP));
    tick(); quiet();
    tick(); tick();

    // sft beats tmr, level irq retriggers back to back
    bus.pc_ex_i = 32'h44; bus.ex_valid_i = 1;
    bus.i_sft_irq = 1; bus.i_tmr_irq = 1;
    tick();
    #1 chk("sft_cause", bus.o_mcause, 32'h80000003);
    repeat (6) tick();
    quiet();
    tick(); tick(); tick();

    // Reset in TRAP_SAVE
    bus.pc_ex_i = 32'h300; bus.ex_valid_i = 1;
    bus.i_tmr_irq = 1;
    tick(); quiet();
    rst_n = 1'b0;
    #1 chk("rst_save_irq", 32'(bus.o_irq_src), 32'h0);
    chk("rst_save_hold", 32'(bus.o_hold), 32'h0);
    tick();
    #1 chk("rst_idle_cause", bus.o_mcause, 32'h0);
    chk("rst_idle_pc", bus.o_trap_pc, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("rst_no_jump", 32'(bus.o_jump_ena), 32'h0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL provide these ports: clk, in, 1, core clock; rst_n, in, 1, reset, synchronous, active-low.
REQ-002 SHALL provide these EX-stage inputs: pc_ex_i, in, `BUS_ADDR_MEM`, PC in EX; ex_valid_i, in, 1, EX holds a valid instruction; ecall_i, ebreak_i, mret_i, in, 1 each, decoded EX instruction.
REQ-003 SHALL provide these interrupt inputs: i_ext_irq, i_sft_irq, i_tmr_irq, in, 1 each, level-sensitive requests.
REQ-004 SHALL provide these inputs from ex_csr: meie_i, msie_i, mtie_i, glb_irq_i, in, 1 each; mtvec_i, mepc_i, in, `BUS_ADDR_MEM`.
REQ-005 SHALL provide these outputs to ex_csr: o_irq_src, o_exp_src, o_mret_ena, out, 1 each, one-cycle pulses; o_mcause, out, `BUS_DATA_REG`; o_trap_pc, out, `BUS_ADDR_MEM`, the value to write into mepc.
REQ-006 SHALL provide these pipeline-control outputs: o_hold, out, 1, stall IF/ID/EX; o_flush, out, 1, kill IF/ID/EX; o_jump_ena, out, 1; o_jump_addr, out, `BUS_ADDR_MEM`.

Function
REQ-007 SHALL implement the FSM states IDLE, TRAP_SAVE, TRAP_JUMP, MRET_RST and MRET_JUMP, with encodings defined in define.v.
REQ-008 SHALL evaluate trap candidates in IDLE only, and only when ex_valid_i=1, using priority ecall > ebreak > mret > ext > sft > tmr.
REQ-009 SHALL treat an interrupt as taken only when glb_irq_i=1, its enable is set, and its request is high; irq inputs are not latched.
REQ-010 SHALL, on the detect cycle in IDLE, assert o_hold combinationally and register o_mcause and o_trap_pc=pc_ex_i; the next state is TRAP_SAVE for a trap or MRET_RST for mret.
REQ-011 SHALL use these mcause values: ext 0x8000000B, sft 0x80000003, tmr 0x80000007, ecall 0x0000000B, ebreak 0x00000003, zero-extended or truncated to `BUS_DATA_REG`.
REQ-012 SHALL, in TRAP_SAVE, pulse o_irq_src (interrupt) or o_exp_src (exception) for exactly one cycle, assert o_hold, and then go to TRAP_JUMP.
REQ-013 SHALL, in TRAP_JUMP, assert o_jump_ena=1 and o_flush=1 with o_jump_addr={mtvec_i[MSB:2],2'b00} (direct mode only), and then return to IDLE.
REQ-014 SHALL, in MRET_RST, pulse o_mret_ena for one cycle and assert o_hold, and then go to MRET_JUMP.
REQ-015 SHALL, in MRET_JUMP, assert o_jump_ena=1 and o_flush=1 with o_jump_addr=mepc_i, and then return to IDLE.
REQ-016 SHALL give every trap a latency of 3 cycles from the detect cycle to the jump cycle inclusive, with o_hold high for the first 2 of those cycles.
REQ-017 SHALL ignore all trap inputs in non-IDLE states, so there is no nesting and no queuing.
REQ-018 SHALL hold the registered o_mcause and o_trap_pc stable from TRAP_SAVE through TRAP_JUMP.
REQ-019 SHALL treat simultaneous ecall and interrupt as ecall only; the interrupt is re-evaluated once the FSM returns to IDLE.
REQ-020 SHALL cause no trap when ex_valid_i=0, including while a bubble is in EX.

Reset
REQ-021 SHALL, when rst_n=0 at a clk edge, force the FSM to IDLE and clear o_mcause and o_trap_pc to 0, regardless of the current state.
REQ-022 SHALL, during reset, drive all pulse, hold, flush and jump outputs to 0 and o_jump_addr to 0.
REQ-023 SHALL abandon any trap sequence in progress when reset is asserted mid-sequence, with no partial pulses after release.

Configuration
REQ-024 SHALL, with macro TRAP_CTRL_EXP_EN defined, implement ecall/ebreak exception handling as specified above.
REQ-025 SHALL, without TRAP_CTRL_EXP_EN, ignore ecall_i and ebreak_i, tie o_exp_src to 0, and leave only the interrupt and mret paths.

Structure
REQ-026 SHALL place the FSM state encodings, the mcause constants and the bus widths in define.v.
REQ-027 SHALL implement prioritisation and mcause encoding as the combinational sub-module trap_arb; the FSM and registers stay in trap_ctrl.

Verification
REQ-028 SHALL cover: timer interrupt with glb_irq_i=1, mtie_i=1, i_tmr_irq=1, pc_ex_i=0x100, mtvec_i=0x80 -> o_irq_src pulse, o_mcause=0x80000007, o_trap_pc=0x100, then o_jump_addr=0x80 with o_flush.
REQ-029 SHALL cover: ecall at pc_ex_i=0x200 with i_ext_irq=1 simultaneously -> o_exp_src pulse and o_mcause=0x0B; no o_irq_src during the sequence.
REQ-030 SHALL cover: mret with mepc_i=0x104 -> o_mret_ena pulse one cycle after detect, then o_jump_ena with o_jump_addr=0x104.
REQ-031 SHALL cover: i_ext_irq=1 with glb_irq_i=0, or with ex_valid_i=0 -> FSM stays IDLE and all outputs stay 0.
REQ-032 SHALL cover: rst_n=0 asserted in TRAP_SAVE -> next cycle IDLE, all outputs 0, and no o_jump_ena after release.
REQ-033 SHALL cover: build without TRAP_CTRL_EXP_EN and ebreak_i=1 -> no trap and o_exp_src=0.
